// File: rtl/kamacore_pkg.sv
// Shared kamacore types and constants: datapath widths, opcodes and the fetch FSM encoding.
package kamacore_pkg;

  localparam int CPU_WIDTH  = 32;
  localparam int ADDR_WIDTH = 10;

  localparam logic [6:0]  OPCODE_SB_TYPE = 7'b110_0011;
  localparam logic [31:0] INST_NOP       = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/kamacore_fetch_predecode.sv
// Combinational predecode for static backward-taken branch prediction.
// Flags conditional branches with a negative offset and computes their byte target.
module kamacore_fetch_predecode
  import kamacore_pkg::*;
(
  input  logic [CPU_WIDTH-1:0] inst,
  input  logic [CPU_WIDTH-1:0] pc,
  output logic                 is_back_branch,
  output logic [CPU_WIDTH-1:0] target
);

  logic [CPU_WIDTH-1:0] b_imm;

  // B-type immediate: sign, imm[11], imm[10:5], imm[4:1], implicit zero LSB.
  assign b_imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};

  assign is_back_branch = (inst[6:0] == OPCODE_SB_TYPE) && inst[31];
  assign target         = pc + b_imm;

endmodule

// File: rtl/kamacore_fetch.sv
// Instruction fetch stage: PC register, BOOT/RUN/FLUSH FSM and a one-entry output slot.
// Define KAMACORE_FETCH_BP_EN to enable static backward-taken branch prediction.
module kamacore_fetch
  import kamacore_pkg::*;
#(
  parameter int                   MEM_ADDR_WIDTH = ADDR_WIDTH,
  parameter logic [CPU_WIDTH-1:0] RESET_PC       = 32'h0
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic [MEM_ADDR_WIDTH-1:0] imem_addr,
  input  logic [CPU_WIDTH-1:0]      imem_data,
  input  logic                      redirect_valid,
  input  logic [CPU_WIDTH-1:0]      redirect_pc,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CPU_WIDTH-1:0]      out_inst,
  output logic [CPU_WIDTH-1:0]      out_pc,
  output logic                      out_pred_taken
);

  // Fetchable byte range; next_pc wraps inside it.
  localparam logic [CPU_WIDTH-1:0] PC_MASK = (32'h1 << (MEM_ADDR_WIDTH + 2)) - 32'h1;

  fetch_state_t         state, state_next;
  logic [CPU_WIDTH-1:0] pc;
  logic [CPU_WIDTH-1:0] seq_pc;
  logic [CPU_WIDTH-1:0] next_pc;
  logic                 pred_taken;
  logic                 fetch;
  logic                 unused_redirect_lsb;

  assign imem_addr           = pc[MEM_ADDR_WIDTH+1:2];
  assign unused_redirect_lsb = ^redirect_pc[1:0];

`ifdef KAMACORE_FETCH_BP_EN
  logic [CPU_WIDTH-1:0] branch_target;

  kamacore_fetch_predecode u_predecode (
    .inst           (imem_data),
    .pc             (pc),
    .is_back_branch (pred_taken),
    .target         (branch_target)
  );

  assign seq_pc = pred_taken ? branch_target : (pc + 32'd4);
`else
  assign pred_taken = 1'b0;
  assign seq_pc     = pc + 32'd4;
`endif

  assign next_pc = seq_pc & PC_MASK;

  // Handshake: the slot transfers when out_valid && out_ready; out_valid never drops
  // without a transfer except on redirect or reset, and the slot is frozen while stalled.
  always_comb begin
    state_next = state;
    fetch      = 1'b0;
    case (state)
      BOOT:    state_next = RUN;
      RUN:     fetch      = !out_valid || out_ready;
      FLUSH:   state_next = RUN;
      default: state_next = BOOT;
    endcase
    if (redirect_valid) begin
      state_next = FLUSH;
      fetch      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= BOOT;
      pc    <= RESET_PC;
    end else begin
      state <= state_next;
      if (redirect_valid) begin
        pc <= {redirect_pc[CPU_WIDTH-1:2], 2'b00};
      end else if (fetch) begin
        pc <= next_pc;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid      <= 1'b0;
      out_inst       <= INST_NOP;
      out_pc         <= '0;
      out_pred_taken <= 1'b0;
    end else if (redirect_valid) begin
      out_valid      <= 1'b0;
      out_inst       <= INST_NOP;
      out_pred_taken <= 1'b0;
    end else if (fetch) begin
      out_valid      <= 1'b1;
      out_inst       <= imem_data;
      out_pc         <= pc;
      out_pred_taken <= pred_taken;
    end
  end

endmodule
